// File: rtl/cpu_clk_pkg.sv
// Shared CPU-clock definitions for the hold meter and the divider configuration logic.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a. All frequencies are in 0.1 MHz units, so 250 means 25.0 MHz.
package cpu_clk_pkg;

  // Width of every frequency field (fref, freq, freq_exp), in 0.1 MHz units.
  localparam int FREQ_W = 8;

  typedef logic [FREQ_W-1:0] freq_t;

  // Largest reportable frequency; measurements above this are clamped.
  localparam freq_t FREQ_MAX = '1;

  // A reference below 2 gives a window too short to mean anything.
  localparam freq_t FREF_MIN = freq_t'(2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  // True when |meas - exp_f| exceeds tol. A 9-bit signed difference keeps
  // the full -255..+255 range without wrapping.
  function automatic logic freq_off_tol(freq_t meas, freq_t exp_f, int unsigned tol);
    logic signed [FREQ_W:0] diff;
    logic        [FREQ_W:0] mag;
    diff = $signed({1'b0, meas}) - $signed({1'b0, exp_f});
    mag  = diff[FREQ_W] ? $unsigned(-diff) : $unsigned(diff);
    return (32'(mag) > tol);
  endfunction

endpackage

// File: rtl/hold_meter_if.sv
// Bundle of the hold meter's configuration, observed hold line and results.
// Latency: n/a (wires only).
// Backpressure: none; results are a one-cycle valid strobe with no ready.
interface hold_meter_if
  import cpu_clk_pkg::*;
#(
  parameter int STALL_W = 16
);
  logic               enable;
  logic               hold;
  freq_t              fref;
  freq_t              freq_exp;
  freq_t              freq_meas;
  logic [STALL_W-1:0] max_stall;
  logic               valid;
  logic               mismatch;
  logic               busy;
  logic               cfg_err;

  // Driver side: control logic / testbench.
  modport master (
    output enable, hold, fref, freq_exp,
    input  freq_meas, max_stall, valid, mismatch, busy, cfg_err
  );

  // Meter side.
  modport slave (
    input  enable, hold, fref, freq_exp,
    output freq_meas, max_stall, valid, mismatch, busy, cfg_err
  );
endinterface

// File: rtl/run_len_tracker.sv
// Tracks the current and longest run of hold=0 samples, saturating at all-ones.
// Latency: max_o reflects a sample one cycle after it is taken.
// Backpressure: none; samples only when en_i is high, clr_i wins over en_i.
module run_len_tracker #(
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               hold_i,
  output logic [STALL_W-1:0] max_o
);

  logic [STALL_W-1:0] cur_q, cur_d;
  logic [STALL_W-1:0] max_q, max_d;

  // Next run length and running maximum, including the sample being taken now.
  always_comb begin
    cur_d = cur_q;
    max_d = max_q;
    if (en_i) begin
      if (hold_i) begin
        cur_d = '0;
      end else if (cur_q != '1) begin
        cur_d = cur_q + STALL_W'(1);
      end
      max_d = (cur_d > max_q) ? cur_d : max_q;
    end
  end

  // Run counters; cleared at the start of every window so runs never span two.
  always_ff @(posedge clock) begin
    if (reset || clr_i) begin
      cur_q <= '0;
      max_q <= '0;
    end else begin
      cur_q <= cur_d;
      max_q <= max_d;
    end
  end

  assign max_o = max_q;

endmodule

// File: rtl/hold_meter.sv
// Measures effective CPU frequency from the hold line over fref<<AVG_LOG2 cycles.
// Latency: valid strobes fref_l<<AVG_LOG2 + 2 cycles after leaving IDLE, then every window+2.
// Backpressure: none; enable=0 aborts a window, results simply overwrite on each valid.
module hold_meter
  import cpu_clk_pkg::*;
#(
  parameter int          AVG_LOG2 = 2,
  parameter int unsigned TOL      = 2,
  parameter int          STALL_W  = 16
) (
  input  logic  clock,
  input  logic  reset,
  hold_meter_if.slave bus
);

  // Counters wide enough for 255 << AVG_LOG2 samples, so they cannot overflow.
  localparam int CNT_W   = FREQ_W + AVG_LOG2;
  // Half an LSB of the averaged result, for round-to-nearest.
  localparam int RND_ADD = (2 ** AVG_LOG2) / 2;

  state_t state_q, state_d;

  logic busy;
  logic arm_go;
  logic meas_step;
  logic meas_last;
  logic rpt_go;
  logic cfg_hit;

  freq_t            fref_l_q;
  freq_t            freq_exp_l_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [CNT_W-1:0] win_len;

  logic [CNT_W:0]     rnd_sum;
  logic [CNT_W:0]     rnd_res;
  freq_t              freq_new;
  logic [STALL_W-1:0] max_run;

  freq_t              freq_meas_q;
  logic [STALL_W-1:0] max_stall_q;
  logic               valid_q;
  logic               mismatch_q;
  logic               cfg_err_q;

  assign win_len   = CNT_W'(fref_l_q) << AVG_LOG2;
  assign meas_last = (cyc_q == win_len - CNT_W'(1));

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enable low aborts ARM/MEASURE but lets REPORT finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!bus.enable)              state_d = ST_IDLE;
        else if (bus.fref < FREF_MIN) state_d = ST_IDLE;
        else                          state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!bus.enable)    state_d = ST_IDLE;
        else if (meas_last) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        state_d = bus.enable ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: per-state strobes driving the datapath.
  always_comb begin
    busy      = (state_q == ST_MEASURE);
    arm_go    = (state_q == ST_ARM) && bus.enable;
    meas_step = (state_q == ST_MEASURE) && bus.enable;
    rpt_go    = (state_q == ST_REPORT);
    cfg_hit   = arm_go && (bus.fref < FREF_MIN);
  end

  // Window bookkeeping: latch config at ARM, count samples and run cycles in MEASURE.
  always_ff @(posedge clock) begin
    if (reset) begin
      fref_l_q     <= '0;
      freq_exp_l_q <= '0;
      cyc_q        <= '0;
      run_cnt_q    <= '0;
    end else if (arm_go) begin
      fref_l_q     <= bus.fref;
      freq_exp_l_q <= bus.freq_exp;
      cyc_q        <= '0;
      run_cnt_q    <= '0;
    end else if (meas_step) begin
      cyc_q        <= cyc_q + CNT_W'(1);
      run_cnt_q    <= run_cnt_q + CNT_W'(bus.hold);
    end
  end

  run_len_tracker #(
    .STALL_W (STALL_W)
  ) u_run_len (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (arm_go),
    .en_i   (meas_step),
    .hold_i (bus.hold),
    .max_o  (max_run)
  );

  // Average the run count back to 0.1 MHz units, rounded and clamped.
  always_comb begin
    rnd_sum  = {1'b0, run_cnt_q} + (CNT_W+1)'(RND_ADD);
    rnd_res  = rnd_sum >> AVG_LOG2;
    freq_new = (rnd_res > (CNT_W+1)'(FREQ_MAX)) ? FREQ_MAX : rnd_res[FREQ_W-1:0];
  end

  // Result registers: written only by REPORT, so an aborted window leaves them as they were.
  always_ff @(posedge clock) begin
    if (reset) begin
      freq_meas_q <= '0;
      max_stall_q <= '0;
      valid_q     <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      valid_q <= rpt_go;
      if (rpt_go) begin
        freq_meas_q <= freq_new;
        max_stall_q <= max_run;
        mismatch_q  <= freq_off_tol(freq_new, freq_exp_l_q, TOL);
      end
    end
  end

  // Config error: set by a bad fref at ARM, held until enable is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_err_q <= 1'b0;
    end else if (!bus.enable) begin
      cfg_err_q <= 1'b0;
    end else if (cfg_hit) begin
      cfg_err_q <= 1'b1;
    end
  end

  assign bus.freq_meas = freq_meas_q;
  assign bus.max_stall = max_stall_q;
  assign bus.valid     = valid_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.busy      = busy;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_hold_meter.sv
// Directed bench for hold_meter: two instances (AVG_LOG2=2 and AVG_LOG2=0).
// Hold patterns are generated as run/stall duty cycles advanced once per clock.
// Every comparison is an immediate assertion against a hand-computed value.
module tb_hold_meter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  hold_meter_if #(.STALL_W(16)) ifa ();
  hold_meter_if #(.STALL_W(16)) ifb ();

  hold_meter #(.AVG_LOG2(2), .TOL(2), .STALL_W(16)) u_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  hold_meter #(.AVG_LOG2(0), .TOL(2), .STALL_W(16)) u_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int pat_run  = 1;
  int pat_stall = 0;
  int pat_ph   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive_hold();
    logic h;
    h = (pat_ph < pat_run);
    ifa.hold = h;
    ifb.hold = h;
    pat_ph = (pat_ph + 1) % (pat_run + pat_stall);
  endtask

  task automatic set_pat(input int r, input int s);
    pat_run   = r;
    pat_stall = s;
    pat_ph    = 0;
    drive_hold();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    drive_hold();
  endtask

  task automatic wait_valid(input bit sel, input int budget, output int n, output logic seen);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      seen = sel ? ifb.valid : ifa.valid;
    end
  endtask

  initial begin
    int   n;
    logic seen;
    int   n_vld;
    int   n_bsy;

    reset = 1'b1;
    ifa.enable = 1'b0; ifa.fref = '0; ifa.freq_exp = '0;
    ifb.enable = 1'b0; ifb.fref = '0; ifb.freq_exp = '0;
    set_pat(1, 0);
    repeat (3) tick();

    chk("rst_freq_meas", ifa.freq_meas, 0);
    chk("rst_max_stall", ifa.max_stall, 0);
    chk("rst_valid",     ifa.valid, 0);
    chk("rst_mismatch",  ifa.mismatch, 0);
    chk("rst_busy",      ifa.busy, 0);
    chk("rst_cfg_err",   ifa.cfg_err, 0);
    chk("rst_b_freq",    ifb.freq_meas, 0);
    chk("rst_b_valid",   ifb.valid, 0);
    reset = 1'b0;
    tick();

    // 1: 125 run / 125 stall at fref=250, window 1000
    ifa.fref = 8'd250; ifa.freq_exp = 8'd125; set_pat(125, 125); ifa.enable = 1'b1;
    wait_valid(0, 1100, n, seen);
    chk("t1_seen",      seen, 1);
    chk("t1_latency",   n, 1003);
    chk("t1_freq",      ifa.freq_meas, 125);
    chk("t1_stall",     ifa.max_stall, 125);
    chk("t1_mismatch",  ifa.mismatch, 0);
    tick();
    chk("t1_pulse",     ifa.valid, 0);
    chk("t1_busy",      ifa.busy, 1);
    wait_valid(0, 1100, n, seen);
    chk("t1_seen2",     seen, 1);
    chk("t1_period",    n + 1, 1002);
    chk("t1_freq2",     ifa.freq_meas, 125);
    chk("t1_stall2",    ifa.max_stall, 125);

    // 2: hold tied 1, freq_exp=240 -> off by 10
    ifa.enable = 1'b0;
    repeat (2) tick();
    chk("t2_idle_busy", ifa.busy, 0);
    chk("t2_hold_freq", ifa.freq_meas, 125);
    ifa.freq_exp = 8'd240; set_pat(1, 0); ifa.enable = 1'b1;
    wait_valid(0, 1100, n, seen);
    chk("t2_latency",   n, 1003);
    chk("t2_freq",      ifa.freq_meas, 250);
    chk("t2_stall",     ifa.max_stall, 0);
    chk("t2_mismatch",  ifa.mismatch, 1);

    // 3: hold tied 0 at fref=100, window 400
    ifa.enable = 1'b0;
    repeat (2) tick();
    ifa.fref = 8'd100; ifa.freq_exp = 8'd0; set_pat(0, 1); ifa.enable = 1'b1;
    wait_valid(0, 500, n, seen);
    chk("t3_latency",   n, 403);
    chk("t3_freq",      ifa.freq_meas, 0);
    chk("t3_stall",     ifa.max_stall, 400);
    chk("t3_mismatch",  ifa.mismatch, 0);

    // 4: fref=1 is a configuration error
    ifa.enable = 1'b0;
    repeat (3) tick();
    ifa.fref = 8'd1; ifa.enable = 1'b1;
    repeat (2) tick();
    chk("t4_cfg_err",   ifa.cfg_err, 1);
    chk("t4_busy",      ifa.busy, 0);
    n_vld = 0; n_bsy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifa.valid) n_vld++;
      if (ifa.busy)  n_bsy++;
    end
    chk("t4_no_valid",  n_vld, 0);
    chk("t4_no_busy",   n_bsy, 0);
    chk("t4_sticky",    ifa.cfg_err, 1);
    ifa.enable = 1'b0;
    tick();
    chk("t4_cfg_clr",   ifa.cfg_err, 0);
    ifa.fref = 8'd250; ifa.freq_exp = 8'd250; set_pat(1, 0); ifa.enable = 1'b1;
    wait_valid(0, 1100, n, seen);
    chk("t4_latency",   n, 1003);
    chk("t4_freq",      ifa.freq_meas, 250);
    chk("t4_mismatch",  ifa.mismatch, 0);
    chk("t4_cfg_err2",  ifa.cfg_err, 0);

    // 5: abort in MEASURE, then reset in MEASURE
    repeat (300) tick();
    chk("t5_busy",      ifa.busy, 1);
    set_pat(0, 1); ifa.enable = 1'b0;
    tick();
    chk("t5_abort_busy", ifa.busy, 0);
    chk("t5_abort_vld",  ifa.valid, 0);
    chk("t5_keep_freq",  ifa.freq_meas, 250);
    chk("t5_keep_stall", ifa.max_stall, 0);
    n_vld = 0; n_bsy = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (ifa.valid) n_vld++;
      if (ifa.busy)  n_bsy++;
    end
    chk("t5_no_valid",  n_vld, 0);
    chk("t5_no_busy",   n_bsy, 0);
    set_pat(1, 0); ifa.enable = 1'b1;
    repeat (100) tick();
    chk("t5_busy2",     ifa.busy, 1);
    reset = 1'b1;
    tick();
    chk("t5_rst_freq",  ifa.freq_meas, 0);
    chk("t5_rst_stall", ifa.max_stall, 0);
    chk("t5_rst_valid", ifa.valid, 0);
    chk("t5_rst_busy",  ifa.busy, 0);
    chk("t5_rst_mism",  ifa.mismatch, 0);
    chk("t5_rst_cfg",   ifa.cfg_err, 0);
    ifa.enable = 1'b0;
    reset = 1'b0;
    tick();

    // 6: AVG_LOG2=0, 3 run / 1 stall at fref=8, tolerance edge
    ifb.fref = 8'd8; ifb.freq_exp = 8'd8; set_pat(3, 1); ifb.enable = 1'b1;
    wait_valid(1, 50, n, seen);
    chk("t6_latency",   n, 11);
    chk("t6_freq",      ifb.freq_meas, 6);
    chk("t6_stall",     ifb.max_stall, 1);
    chk("t6_tol_edge",  ifb.mismatch, 0);
    ifb.freq_exp = 8'd9;
    wait_valid(1, 50, n, seen);
    chk("t6_period",    n, 10);
    chk("t6_freq2",     ifb.freq_meas, 6);
    chk("t6_tol_over",  ifb.mismatch, 1);
    ifb.enable = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
